timer_compare_irq: RTL and testbench
====================================

TIMER_COMPARE_IRQ -- requirements
Module: timer_compare_irq

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of counter_value and the compare/period registers.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port address  input  2  Avalon-MM word address: 0 CTRL, 1 COMPARE, 2 PERIOD, 3 STATUS.
REQ-005 SHALL have port read  input  1  Avalon-MM read strobe.
REQ-006 SHALL have port write  input  1  Avalon-MM write strobe.
REQ-007 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-008 SHALL have port readdata  output  32  Avalon-MM read data, registered.
REQ-009 SHALL have port counter_value  input  CNT_W  live count from the upstream timer peripheral.
REQ-010 SHALL have port irq  output  1  level interrupt request to the Nios II.

Function
REQ-011 CTRL SHALL be bit0 ARM, bit1 IE, bit2 PERIODIC, bits 31:3 reading 0.
REQ-012 STATUS SHALL be bit0 MATCH, bit1 OVERRUN, bits 31:2 reading 0; writing 1 clears a bit, writing 0 leaves it unchanged.
REQ-013 readdata SHALL load the addressed register on the rising edge where read=1, giving one-cycle latency, and hold its value otherwise.
REQ-014 The block SHALL keep prev_cnt, a copy of counter_value registered every cycle.
REQ-015 A hit SHALL occur in a cycle where counter_value==COMPARE and counter_value!=prev_cnt, so a stopped counter never re-hits.
REQ-016 The FSM SHALL have states IDLE, ARMED and FIRED.
REQ-017 A CTRL write with ARM=1 SHALL move IDLE or FIRED to ARMED; a CTRL write with ARM=0 SHALL move any state to IDLE.
REQ-018 A hit is acted on only in ARMED; on a hit, MATCH SHALL set, and OVERRUN SHALL set if MATCH was already 1.
REQ-019 On a hit with PERIODIC=0, the FSM SHALL move to FIRED, and CTRL.ARM SHALL read 0.
REQ-020 On a hit with PERIODIC=1, the FSM SHALL stay ARMED and COMPARE SHALL become COMPARE+PERIOD modulo 2^CNT_W, with wrap-around allowed and no flag raised.
REQ-021 PERIOD=0 with PERIODIC=1 SHALL leave COMPARE unchanged, so the next hit requires the counter to leave and return to the value.
REQ-022 irq SHALL equal STATUS.MATCH AND CTRL.IE, driven from registered bits with no combinational path from bus inputs.
REQ-023 A match-set and a write-1-clear of MATCH in the same cycle: set SHALL win (MATCH=1), and OVERRUN SHALL be unchanged.
REQ-024 A COMPARE write in the same cycle as a hit: the hit SHALL use the old COMPARE, the written value SHALL be stored, and the periodic reload SHALL be suppressed.
REQ-025 A CTRL write with ARM=0 in the same cycle as a hit: the hit SHALL be ignored (no flag set).
REQ-026 Writes to PERIOD SHALL take effect for the next reload only.
REQ-027 A read and a write in the same cycle SHALL return the pre-write register value.
REQ-028 Reads SHALL have no side effects.

Reset
REQ-029 While reset=0, all registers SHALL be cleared asynchronously: CTRL=0, COMPARE=0, PERIOD=0, STATUS=0, prev_cnt=0, FSM=IDLE, readdata=0, irq=0.
REQ-030 Deassertion of reset SHALL be sampled synchronously; the first hit can occur on the second rising clk edge after release.
REQ-031 Reset asserted mid-operation SHALL drop irq within the same reset assertion and discard any pending reload.

Verification
REQ-032 One-shot: COMPARE=100, CTRL=0x3, counter ramps 0..200 -> MATCH=1 and irq=1 at count 100, no further hit, CTRL reads 0x2, FSM FIRED.
REQ-033 Periodic: COMPARE=10, PERIOD=10, CTRL=0x7, counter ramps 0..45 -> hits at 10/20/30/40, COMPARE reads 50, OVERRUN=1 with no clears in between.
REQ-034 Clear race: write STATUS=0x1 in the hit cycle -> MATCH stays 1 and irq stays 1; a later write of 0x3 -> STATUS=0 and irq=0.
REQ-035 Stopped counter: counter held at 100, COMPARE=100, then ARM -> no hit; counter to 101, back to 0, then ramps to 100 -> single hit.
REQ-036 Wrap: COMPARE=0xFFFFFFF0, PERIOD=0x20, periodic, counter reaches 0xFFFFFFF0 -> COMPARE reads 0x00000010.
REQ-037 Reset: assert reset=0 while irq=1 and ARMED -> irq=0 immediately and all registers read 0 after release.

Source files
------------

// File: rtl/timer_compare_irq_if.sv
// rtl/timer_compare_irq_if.sv - Avalon-MM register bus bundle for timer_compare_irq
// Signals: address[1:0], read, write, writedata[31:0] driven by the master;
//          readdata[31:0] driven by the slave (registered, one-cycle latency).
interface timer_compare_irq_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/timer_compare_irq.sv
// rtl/timer_compare_irq.sv - compare-match interrupt block watching an external timer count
// Ports:
//   clk           - single clock, rising edge
//   reset         - asynchronous active-low reset
//   bus           - Avalon-MM slave: 0 CTRL, 1 COMPARE, 2 PERIOD, 3 STATUS
//   counter_value - live count from the upstream timer
//   irq           - level interrupt, STATUS.MATCH & CTRL.IE
module timer_compare_irq #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  timer_compare_irq_if.slave bus,
  input  logic [CNT_W-1:0]   counter_value,
  output logic               irq
);

  localparam logic [1:0] A_CTRL    = 2'd0;
  localparam logic [1:0] A_COMPARE = 2'd1;
  localparam logic [1:0] A_PERIOD  = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;

  state_t           state_q, state_d;
  logic             ie_q, ie_d;
  logic             periodic_q, periodic_d;
  logic [CNT_W-1:0] compare_q, compare_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             match_q, match_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] prev_cnt_q;
  logic [31:0]      readdata_q, readdata_d;

  logic             ctrl_wr, compare_wr, period_wr, status_wr;
  logic             hit, act_hit;
  logic [1:0]       clr;

  assign ctrl_wr    = bus.write && (bus.address == A_CTRL);
  assign compare_wr = bus.write && (bus.address == A_COMPARE);
  assign period_wr  = bus.write && (bus.address == A_PERIOD);
  assign status_wr  = bus.write && (bus.address == A_STATUS);
  assign clr        = status_wr ? bus.writedata[1:0] : 2'b00;

  // The count must have just moved onto COMPARE, so a parked counter never re-hits.
  assign hit = (counter_value == compare_q) && (counter_value != prev_cnt_q);

  // A disarming CTRL write wins over a coincident hit.
  assign act_hit = (state_q == ARMED) && hit && !(ctrl_wr && !bus.writedata[0]);

  always_comb begin
    state_d    = state_q;
    ie_d       = ie_q;
    periodic_d = periodic_q;
    compare_d  = compare_q;
    period_d   = period_q;
    match_d    = match_q & ~clr[0];
    overrun_d  = overrun_q & ~clr[1];
    readdata_d = readdata_q;

    if (act_hit) begin
      match_d = 1'b1;
      // Overrun records a hit landing on an unserviced match; the clear
      // half of a same-cycle write does not disturb it.
      overrun_d = match_q ? 1'b1 : overrun_q;
      if (!periodic_q) begin
        state_d = FIRED;
      end else if (!compare_wr) begin
        // Software's COMPARE write supersedes the periodic reload.
        compare_d = compare_q + period_q;
      end
    end

    if (ctrl_wr) begin
      ie_d       = bus.writedata[1];
      periodic_d = bus.writedata[2];
      state_d    = bus.writedata[0] ? ARMED : IDLE;
    end
    if (compare_wr) compare_d = CNT_W'(bus.writedata);
    if (period_wr)  period_d  = CNT_W'(bus.writedata);

    // Reads sample pre-write register values.
    if (bus.read) begin
      unique case (bus.address)
        A_CTRL:    readdata_d = {29'd0, periodic_q, ie_q, state_q == ARMED};
        A_COMPARE: readdata_d = 32'(compare_q);
        A_PERIOD:  readdata_d = 32'(period_q);
        A_STATUS:  readdata_d = {30'd0, overrun_q, match_q};
        default:   readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ie_q       <= 1'b0;
      periodic_q <= 1'b0;
      compare_q  <= '0;
      period_q   <= '0;
      match_q    <= 1'b0;
      overrun_q  <= 1'b0;
      prev_cnt_q <= '0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      periodic_q <= periodic_d;
      compare_q  <= compare_d;
      period_q   <= period_d;
      match_q    <= match_d;
      overrun_q  <= overrun_d;
      prev_cnt_q <= counter_value;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = match_q & ie_q;

endmodule

// File: tb/tb_timer_compare_irq.sv
// tb/tb_timer_compare_irq.sv - directed self-checking bench for timer_compare_irq
module tb_timer_compare_irq;

  logic        clk;
  logic        reset;
  logic [31:0] counter_value;
  logic        irq;
  logic [31:0] d;

  int n_cmp;
  int n_bad;

  timer_compare_irq_if bus ();

  timer_compare_irq #(.CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .counter_value (counter_value),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    bus.address   = a;
    bus.writedata = v;
    bus.write     = 1'b1;
    tick();
    bus.write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.address = a;
    bus.read    = 1'b1;
    tick();
    bus.read    = 1'b0;
    v = bus.readdata;
  endtask

  task automatic set_cnt(input logic [31:0] v);
    counter_value = v;
    tick();
  endtask

  task automatic ramp(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) set_cnt(32'(i));
  endtask

  task automatic cleanup();
    wr(2'd0, 32'd0);
    wr(2'd3, 32'd3);
    set_cnt(32'd0);
    set_cnt(32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    counter_value = 32'd0;
    bus.address = 2'd0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.writedata = 32'd0;

    // Reset state
    repeat (3) tick();
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", bus.readdata, 32'd0);
    reset = 1'b1;
    tick();
    rd(2'd0, d); check("rst_ctrl", d, 32'd0);
    rd(2'd1, d); check("rst_compare", d, 32'd0);
    rd(2'd2, d); check("rst_period", d, 32'd0);
    rd(2'd3, d); check("rst_status", d, 32'd0);

    // One-shot
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h3);
    ramp(0, 99);
    check("os_irq_pre", {31'd0, irq}, 32'd0);
    set_cnt(32'd100);
    check("os_irq_hit", {31'd0, irq}, 32'd1);
    ramp(101, 200);
    check("os_irq_post", {31'd0, irq}, 32'd1);
    rd(2'd3, d); check("os_status", d, 32'h1);
    rd(2'd0, d); check("os_ctrl", d, 32'h2);

    // Periodic
    cleanup();
    check("clean_irq", {31'd0, irq}, 32'd0);
    wr(2'd1, 32'd10);
    wr(2'd2, 32'd10);
    wr(2'd0, 32'h7);
    ramp(0, 10);
    check("per_irq10", {31'd0, irq}, 32'd1);
    ramp(11, 45);
    rd(2'd1, d); check("per_compare", d, 32'd50);
    rd(2'd3, d); check("per_status", d, 32'h3);
    rd(2'd0, d); check("per_ctrl", d, 32'h7);

    // Clear race
    cleanup();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h3);
    ramp(1, 4);
    counter_value = 32'd5;
    wr(2'd3, 32'h1);
    check("race_irq", {31'd0, irq}, 32'd1);
    rd(2'd3, d); check("race_status", d, 32'h1);
    wr(2'd3, 32'h3);
    rd(2'd3, d); check("race_clr_status", d, 32'h0);
    check("race_clr_irq", {31'd0, irq}, 32'd0);

    // Stopped counter
    cleanup();
    set_cnt(32'd100);
    set_cnt(32'd100);
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h3);
    repeat (4) tick();
    rd(2'd3, d); check("stop_nohit", d, 32'h0);
    set_cnt(32'd101);
    set_cnt(32'd0);
    ramp(1, 100);
    rd(2'd3, d); check("stop_status", d, 32'h1);
    rd(2'd0, d); check("stop_ctrl", d, 32'h2);

    // PERIOD=0 periodic: COMPARE stays, counter must leave and return
    cleanup();
    wr(2'd2, 32'd0);
    wr(2'd1, 32'd50);
    wr(2'd0, 32'h7);
    ramp(1, 50);
    repeat (5) set_cnt(32'd50);
    rd(2'd3, d); check("p0_status1", d, 32'h1);
    rd(2'd1, d); check("p0_compare", d, 32'd50);
    set_cnt(32'd51);
    set_cnt(32'd50);
    rd(2'd3, d); check("p0_status2", d, 32'h3);
    rd(2'd0, d); check("p0_ctrl", d, 32'h7);

    // Wrap-around reload, IE off
    cleanup();
    wr(2'd2, 32'h20);
    wr(2'd1, 32'hFFFF_FFF0);
    wr(2'd0, 32'h5);
    set_cnt(32'hFFFF_FFEF);
    set_cnt(32'hFFFF_FFF0);
    rd(2'd1, d); check("wrap_compare", d, 32'h10);
    rd(2'd3, d); check("wrap_status", d, 32'h1);
    check("wrap_irq_ie0", {31'd0, irq}, 32'd0);

    // COMPARE write coinciding with a periodic hit
    cleanup();
    wr(2'd2, 32'd10);
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h5);
    ramp(1, 19);
    counter_value = 32'd20;
    wr(2'd1, 32'd77);
    rd(2'd1, d); check("cmpwr_compare", d, 32'd77);
    rd(2'd3, d); check("cmpwr_status", d, 32'h1);

    // Disarm coinciding with a hit
    cleanup();
    wr(2'd1, 32'd30);
    wr(2'd0, 32'h3);
    ramp(1, 29);
    counter_value = 32'd30;
    wr(2'd0, 32'h0);
    rd(2'd3, d); check("disarm_status", d, 32'h0);
    rd(2'd0, d); check("disarm_ctrl", d, 32'h0);

    // Read and write same register in one cycle
    wr(2'd1, 32'h1234);
    bus.address   = 2'd1;
    bus.writedata = 32'h5678;
    bus.read      = 1'b1;
    bus.write     = 1'b1;
    tick();
    bus.read  = 1'b0;
    bus.write = 1'b0;
    check("rw_old", bus.readdata, 32'h1234);
    rd(2'd1, d); check("rw_new", d, 32'h5678);

    // Reset mid-operation
    cleanup();
    wr(2'd2, 32'd7);
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h3);
    ramp(1, 10);
    check("mid_irq_pre", {31'd0, irq}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_irq_async", {31'd0, irq}, 32'd0);
    check("mid_rdata_async", bus.readdata, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    rd(2'd0, d); check("mid_ctrl", d, 32'd0);
    rd(2'd1, d); check("mid_compare", d, 32'd0);
    rd(2'd2, d); check("mid_period", d, 32'd0);
    rd(2'd3, d); check("mid_status", d, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
